// File: rtl/mem_pkg.sv
// Shared definitions for memory-interface initiators: access size encodings,
// initiator FSM states and the alignment rule.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_R = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_init_state_t;

  // Natural alignment: halves on even addresses, words on multiples of four.
  function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_H:  mis = addr_lo[0];
      SIZE_W:  mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data/mask placement and load
// data extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_lane_data,
  output logic [3:0]  st_mask,
  input  logic [1:0]  ld_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [4:0]  st_shamt_s;
  logic [4:0]  ld_shamt_s;
  logic [31:0] ld_shifted_s;

  assign st_shamt_s   = {st_addr_lo, 3'b000};
  assign ld_shamt_s   = {ld_addr_lo, 3'b000};
  assign ld_shifted_s = ld_rdata >> ld_shamt_s;

  // Store side: move right-justified data into its lanes and enable them.
  always_comb begin
    st_lane_data = 32'h0000_0000;
    st_mask      = 4'b0000;
    case (st_size)
      SIZE_B: begin
        st_lane_data = {24'h00_0000, st_wdata[7:0]} << st_shamt_s;
        st_mask      = 4'b0001 << st_addr_lo;
      end
      SIZE_H: begin
        st_lane_data = {16'h0000, st_wdata[15:0]} << st_shamt_s;
        st_mask      = 4'b0011 << st_addr_lo;
      end
      SIZE_W: begin
        st_lane_data = st_wdata;
        st_mask      = 4'b1111;
      end
      default: begin
        st_lane_data = 32'h0000_0000;
        st_mask      = 4'b0000;
      end
    endcase
  end

  // Load side: right-justify, truncate to size, then extend.
  always_comb begin
    ld_data = 32'h0000_0000;
    case (ld_size)
      SIZE_B: begin
        if (ld_unsigned) begin
          ld_data = {24'h00_0000, ld_shifted_s[7:0]};
        end else begin
          ld_data = {{24{ld_shifted_s[7]}}, ld_shifted_s[7:0]};
        end
      end
      SIZE_H: begin
        if (ld_unsigned) begin
          ld_data = {16'h0000, ld_shifted_s[15:0]};
        end else begin
          ld_data = {{16{ld_shifted_s[15]}}, ld_shifted_s[15:0]};
        end
      end
      SIZE_W:  ld_data = ld_shifted_s;
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_initiator.sv
// Initiator for the single-port memory interface: accepts core load/store
// requests, issues one strobe, waits for done and returns an extended result.
module mem_initiator
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_wstrobe,
  output logic        mem_rstrobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  mem_init_state_t state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_wmask_q, mem_wmask_d;
  logic             mem_wstrobe_q, mem_wstrobe_d;
  logic             mem_rstrobe_q, mem_rstrobe_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;

  logic [31:0] st_lane_s;
  logic [3:0]  st_mask_s;
  logic [31:0] ld_data_s;
  logic        acc_err_s;

  mem_lane_align u_align (
    .st_addr_lo   (req_addr[1:0]),
    .st_size      (req_size),
    .st_wdata     (req_wdata),
    .st_lane_data (st_lane_s),
    .st_mask      (st_mask_s),
    .ld_addr_lo   (mem_addr_q[1:0]),
    .ld_size      (size_q),
    .ld_unsigned  (uns_q),
    .ld_rdata     (mem_rdata),
    .ld_data      (ld_data_s)
  );

  assign acc_err_s = mem_misaligned(req_size, req_addr[1:0]) || (req_size == SIZE_R);

  // Next-state and registered-output logic for the access sequence.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    cnt_d         = '0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wmask_d   = mem_wmask_q;
    mem_wstrobe_d = 1'b0;
    mem_rstrobe_d = 1'b0;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d   = req_we;
          size_d = req_size;
          uns_d  = req_unsigned;
          if (acc_err_s) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d       = ISSUE;
            mem_addr_d    = req_addr;
            mem_wdata_d   = req_we ? st_lane_s : 32'h0000_0000;
            mem_wmask_d   = req_we ? st_mask_s : 4'b0000;
            mem_wstrobe_d = req_we;
            mem_rstrobe_d = !req_we;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_done) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? 32'h0000_0000 : ld_data_s;
          mem_addr_d   = 32'h0000_0000;
          mem_wdata_d  = 32'h0000_0000;
          mem_wmask_d  = 4'b0000;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          mem_addr_d   = 32'h0000_0000;
          mem_wdata_d  = 32'h0000_0000;
          mem_wmask_d  = 4'b0000;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      RESP: state_d = IDLE;
      default: begin
        state_d     = IDLE;
        mem_addr_d  = 32'h0000_0000;
        mem_wdata_d = 32'h0000_0000;
        mem_wmask_d = 4'b0000;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      we_q          <= 1'b0;
      size_q        <= SIZE_B;
      uns_q         <= 1'b0;
      cnt_q         <= '0;
      mem_addr_q    <= 32'h0000_0000;
      mem_wdata_q   <= 32'h0000_0000;
      mem_wmask_q   <= 4'b0000;
      mem_wstrobe_q <= 1'b0;
      mem_rstrobe_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wmask_q   <= mem_wmask_d;
      mem_wstrobe_q <= mem_wstrobe_d;
      mem_rstrobe_q <= mem_rstrobe_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;
  assign mem_wstrobe = mem_wstrobe_q;
  assign mem_rstrobe = mem_rstrobe_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator against a synchronous word memory with a
// programmable done delay; responses are checked from a scoreboard queue.
module tb_mem_initiator;
  import mem_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wstrobe, mem_rstrobe, mem_done;
  logic [31:0] mem_rdata = 32'h0000_0000;

  always #5 clk = ~clk;

  mem_initiator #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wstrobe(mem_wstrobe), .mem_rstrobe(mem_rstrobe),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: word memory, read data registered on the read strobe.
  logic [31:0] mem_q [0:63];
  int   stall_cfg = 0;
  int   stall_cnt = 0;
  logic done_en = 1'b1;
  always @(posedge clk) begin
    if (mem_wstrobe) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) mem_q[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (mem_rstrobe) mem_rdata <= mem_q[mem_addr[7:2]];
    if (mem_wstrobe || mem_rstrobe) stall_cnt <= stall_cfg;
    else if (stall_cnt > 0) stall_cnt <= stall_cnt - 1;
  end
  assign mem_done = done_en && (stall_cnt == 0);

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
    string       tag;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_wstrobe || mem_rstrobe) begin
        strobe_cnt++;
        check1("strobe_exclusive", mem_wstrobe & mem_rstrobe, 1'b0);
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check1("resp_unexpected", resp_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check1({e.tag, "_err"}, resp_err, e.err);
          check32({e.tag, "_rdata"}, resp_rdata, e.rdata);
          check32({e.tag, "_cycle"}, cyc, e.due);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input bit push,
                      input logic exp_err, input logic [31:0] exp_rd, input int lat,
                      input string tag, output int a);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check1({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    a = cyc;
    if (push) sb.push_back('{exp_err, exp_rd, a + lat, tag});
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = 32'h0000_0000;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (sb.size() == 0) && req_ready;
    end
    check1({tag, "_idle"}, ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, a2, sc0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = SIZE_B; req_unsigned = 1'b0; req_wdata = 32'h0;

    #12;
    check1("rst_ready", req_ready, 1'b1);
    check1("rst_resp_valid", resp_valid, 1'b0);
    check1("rst_strobes", mem_wstrobe | mem_rstrobe, 1'b0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload the word at 0x10 through the DUT.
    send(1'b1, 32'h10, SIZE_W, 1'b0, 32'hBEEF_1234, 1'b1, 1'b0, 32'h0, 3, "st_word", a);
    @(negedge clk);
    check1("st_word_wstrobe", mem_wstrobe, 1'b1);
    check32("st_word_mask", {28'h0, mem_wmask}, 32'hF);
    wait_idle("st_word");

    send(1'b0, 32'h12, SIZE_H, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_BEEF, 3, "ld_half_s", a);
    @(negedge clk);
    check1("ld_half_rstrobe", mem_rstrobe, 1'b1);
    check32("ld_half_mask", {28'h0, mem_wmask}, 32'h0);
    wait_idle("ld_half_s");
    send(1'b0, 32'h12, SIZE_H, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_BEEF, 3, "ld_half_u", a);
    wait_idle("ld_half_u");
    send(1'b0, 32'h10, SIZE_B, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0034, 3, "ld_byte_s", a);
    wait_idle("ld_byte_s");

    // Byte store into the top lane.
    send(1'b1, 32'h13, SIZE_B, 1'b0, 32'h0000_00AB, 1'b1, 1'b0, 32'h0, 3, "st_byte", a);
    @(negedge clk);
    check1("st_byte_wstrobe", mem_wstrobe, 1'b1);
    check32("st_byte_mask", {28'h0, mem_wmask}, 32'h8);
    check32("st_byte_wdata", mem_wdata, 32'hAB00_0000);
    check32("st_byte_addr", mem_addr, 32'h13);
    @(negedge clk);
    check1("st_byte_wstrobe_off", mem_wstrobe, 1'b0);
    wait_idle("st_byte");
    send(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, 1'b1, 1'b0, 32'hABEF_1234, 3, "ld_word_merge", a);
    wait_idle("ld_word_merge");
    send(1'b0, 32'h13, SIZE_B, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFAB, 3, "ld_byte_neg", a);
    wait_idle("ld_byte_neg");

    // Rejected accesses: error in A+1, no strobe.
    sc0 = strobe_cnt;
    send(1'b0, 32'h05, SIZE_W, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1, "mis_word", a);
    wait_idle("mis_word");
    send(1'b0, 32'h08, SIZE_R, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1, "rsv_size", a);
    wait_idle("rsv_size");
    send(1'b1, 32'h11, SIZE_H, 1'b0, 32'h1234, 1'b1, 1'b1, 32'h0, 1, "mis_half", a);
    wait_idle("mis_half");
    check32("err_no_strobe", strobe_cnt, sc0);

    // Slow responder: three WAIT cycles with done low.
    stall_cfg = 3;
    sc0 = strobe_cnt;
    send(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, 1'b1, 1'b0, 32'hABEF_1234, 6, "slow", a);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32("slow_addr_hold", mem_addr, 32'h10);
    end
    wait_idle("slow");
    check32("slow_one_strobe", strobe_cnt, sc0 + 1);
    stall_cfg = 0;

    // Timeout with done never asserted.
    done_en = 1'b0;
    send(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, TO + 2, "timeout", a);
    wait_idle("timeout");
    done_en = 1'b1;

    // Reset during WAIT discards the access.
    stall_cfg = 5;
    send(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0, "rst_mid", a);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("rst_mid_ready", req_ready, 1'b1);
    check32("rst_mid_addr", mem_addr, 32'h0);
    check1("rst_mid_resp", resp_valid, 1'b0);
    check1("rst_mid_rstrobe", mem_rstrobe, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stall_cfg = 0;
    repeat (8) @(negedge clk);
    send(1'b0, 32'h12, SIZE_H, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_ABEF, 3, "after_rst", a);
    wait_idle("after_rst");

    // End-to-end store then load, issued as soon as ready returns.
    send(1'b1, 32'h40, SIZE_W, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 3, "e2e_st", a);
    send(1'b0, 32'h40, SIZE_W, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 3, "e2e_ld", a2);
    check32("e2e_back_to_back", a2, a + 4);
    wait_idle("e2e");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
